// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//  req    : read request valid (fetch -> mem)
//  addr   : word-aligned read address (fetch -> mem)
//  gnt    : request accepted this cycle (mem -> fetch)
//  rvalid : read data valid, in order, at least one cycle after grant (mem -> fetch)
//  rdata  : read data (mem -> fetch)
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage producer. Generates the PC, issues instruction-memory reads, buffers
// returned words and presents {inst_f, pc_f, pc4_f} to the fetch/decode register.
// Ports:
//  clk, reset     clock (rising edge), asynchronous active-high reset
//  stall_f        hold the head instruction, do not pop
//  redirect       flush and refetch from redirect_pc (bits [1:0] forced to 0)
//  imem           instruction-memory bus (master side)
//  inst_f/pc_f    head instruction and its PC; pc4_f = pc_f + 4
//  valid_f        head holds a real fetched instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_f,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst_f,
  output logic [31:0]         pc_f,
  output logic [31:0]         pc4_f,
  output logic                valid_f
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Architectural state
  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        out_q, out_d;     // requests granted but not yet returned
  cnt_t        drop_q, drop_d;   // returns still to be discarded after a redirect
  cnt_t        occ_q, occ_d;     // instruction buffer occupancy

  // In-flight PC queue: PCs of granted, non-discarded requests
  logic [31:0] ifq_pc_q [BUF_DEPTH];
  ptr_t        ifq_wr_q, ifq_rd_q;

  // Instruction buffer
  logic [31:0] buf_pc_q   [BUF_DEPTH];
  logic [31:0] buf_inst_q [BUF_DEPTH];
  ptr_t        buf_wr_q, buf_rd_q;

  logic [CW:0] used;
  logic        grant, resp, keep, discard, pop;

  always_comb begin
    used      = {1'b0, out_q} + {1'b0, occ_q};
    // Credit check counts words in flight as already buffered, so the buffer can
    // never overflow regardless of memory latency.
    imem.req  = !reset && !redirect && (used < (CW + 1)'(BUF_DEPTH));
    imem.addr = fetch_pc_q;

    grant   = imem.req && imem.gnt;
    resp    = imem.rvalid && (out_q != '0);
    discard = resp && (drop_q != '0);
    // A word returning during a redirect is part of the flush.
    keep    = resp && (drop_q == '0) && !redirect;
    pop     = valid_f && !stall_f && !redirect;

    out_d      = out_q + cnt_t'(grant) - cnt_t'(resp);
    fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
    drop_d     = drop_q - cnt_t'(discard);
    occ_d      = occ_q + cnt_t'(keep) - cnt_t'(pop);

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      drop_d     = out_d;
      occ_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      occ_q      <= '0;
      ifq_wr_q   <= '0;
      ifq_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      if (redirect) begin
        ifq_wr_q <= '0;
        ifq_rd_q <= '0;
        buf_wr_q <= '0;
        buf_rd_q <= '0;
      end else begin
        if (grant) ifq_wr_q <= ifq_wr_q + ptr_t'(1);
        if (keep) begin
          ifq_rd_q <= ifq_rd_q + ptr_t'(1);
          buf_wr_q <= buf_wr_q + ptr_t'(1);
        end
        if (pop) buf_rd_q <= buf_rd_q + ptr_t'(1);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers/counters.
  always_ff @(posedge clk) begin
    if (grant) ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
    if (keep) begin
      buf_pc_q[buf_wr_q]   <= ifq_pc_q[ifq_rd_q];
      buf_inst_q[buf_wr_q] <= imem.rdata;
    end
  end

  always_comb begin
    valid_f = (occ_q != '0);
    inst_f  = NOP_INST;
    pc_f    = 32'h0;
    pc4_f   = 32'h0;
    if (valid_f) begin
      inst_f = buf_inst_q[buf_rd_q];
      pc_f   = buf_pc_q[buf_rd_q];
      pc4_f  = buf_pc_q[buf_rd_q] + 32'd4;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (reset)
    !(imem.rvalid && (out_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_f, pc_f, pc4_f;
  logic        valid_f;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(DEPTH),
    .NOP_INST (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (bus),
    .inst_f     (inst_f),
    .pc_f       (pc_f),
    .pc4_f      (pc4_f),
    .valid_f    (valid_f)
  );

  always #5 clk = ~clk;

  // Reference model: memory requests in flight (with a stale mark once a redirect
  // makes them unwanted) and the queue of fetched-but-unconsumed PCs.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } fl_t;

  fl_t         fl[$];
  logic [31:0] bq[$];
  logic [31:0] exp_addr;
  int          cyc, last_due, lat;
  int          total, bad;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid_f"}, 32'(valid_f), 32'd0);
    check({tag, "_inst_f"}, inst_f, NOP);
    check({tag, "_pc_f"}, pc_f, 32'h0);
    check({tag, "_pc4_f"}, pc4_f, 32'h0);
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, advance model.
  task automatic step(input bit g, input bit st, input bit rd, input logic [31:0] tgt);
    bit   er, ev;
    fl_t  e;
    int   d;
    bus.gnt     = g;
    stall_f     = st;
    redirect    = rd;
    redirect_pc = tgt;
    if (fl.size() > 0 && fl[0].due <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = word(fl[0].addr);
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
    end
    @(negedge clk);
    er = !rd && (fl.size() + bq.size() < DEPTH);
    ev = bq.size() > 0;
    check("imem_req", 32'(bus.req), 32'(er));
    if (er) check("imem_addr", bus.addr, exp_addr);
    check("valid_f", 32'(valid_f), 32'(ev));
    if (ev) begin
      check("pc_f", pc_f, bq[0]);
      check("inst_f", inst_f, word(bq[0]));
      check("pc4_f", pc4_f, bq[0] + 32'd4);
    end else begin
      check("inst_f_nop", inst_f, NOP);
      check("pc_f_zero", pc_f, 32'h0);
      check("pc4_f_zero", pc4_f, 32'h0);
    end
    if (ev && !st && !rd) void'(bq.pop_front());
    if (bus.rvalid) begin
      e = fl.pop_front();
      if (!e.stale && !rd) bq.push_back(e.addr);
    end
    if (er && g) begin
      d = cyc + ((lat == 0) ? int'($urandom_range(1, 3)) : lat);
      if (d < last_due) d = last_due;
      last_due = d;
      fl.push_back('{addr: exp_addr, due: d, stale: 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    if (rd) begin
      foreach (fl[i]) fl[i].stale = 1'b1;
      bq.delete();
      exp_addr = tgt & ~32'h3;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Asserted between edges; outputs must react without waiting for a clock.
  task automatic do_reset(input string tag);
    reset      = 1'b1;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    stall_f    = 1'b0;
    redirect   = 1'b0;
    redirect_pc = 32'h0;
    #1;
    check({tag, "_imem_req"}, 32'(bus.req), 32'd0);
    check_idle_outputs(tag);
    fl.delete();
    bq.delete();
    exp_addr = RESET_PC;
    last_due = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat   = 1;
    do_reset("reset");

    // Streaming from RESET_PC with a 1-cycle memory until pc 8 heads the buffer.
    n = 0;
    while (!(bq.size() > 0 && bq[0] == 32'h8) && n < 20) begin
      step(1, 0, 0, 0);
      n++;
    end
    check("reach_pc8", 32'(n < 20), 32'd1);

    // Stall for 5 cycles at pc 8, then release.
    repeat (5) step(1, 1, 0, 0);
    repeat (10) step(1, 0, 0, 0);

    // Redirect to 0x103 with two fetches in flight (3-cycle memory).
    lat = 3;
    n = 0;
    while (fl.size() < 2 && n < 20) begin
      step(1, 0, 0, 0);
      n++;
    end
    check("two_in_flight", 32'(fl.size()), 32'd2);
    step(1, 0, 1, 32'h103);
    check("redirect_target", exp_addr, 32'h100);
    repeat (12) step(1, 0, 0, 0);

    // Grant withheld for 4 cycles.
    lat = 1;
    repeat (4) step(0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0);

    // Redirect in a cycle where a response returns and gnt is high.
    n = 0;
    while (!(fl.size() > 0 && fl[0].due <= cyc) && n < 20) begin
      step(1, 0, 0, 0);
      n++;
    end
    check("rvalid_at_redirect", 32'(n < 20), 32'd1);
    step(1, 0, 1, 32'h0000_2000);
    repeat (8) step(1, 0, 0, 0);

    // Randomised traffic: random grant, stall, latency and occasional redirects.
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0), $urandom);
    end

    // Asynchronous reset mid-stream, then restart at RESET_PC.
    lat = 1;
    repeat (3) step(1, 0, 0, 0);
    #2;
    do_reset("midreset");
    repeat (10) step(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
